fm_writer: RTL
==============

FM_WRITER -- requirements
Module: fm_writer

Interface
REQ-001 BASE_LEN, default 2, bits per base; width of in_base and wr_data.
REQ-002 FM_BUFFER_COUNT, default 2, number of ping-pong buffers; fixed at 2.
REQ-003 FM_RAMS_COUNT / FM_ENTRIES_COUNT / FM_OFFSET_COUNT, defaults 2/8/2; FM_BUFFER_SIZE = product = 32 bases per buffer.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  base available on in_base.
REQ-007 in_base  input  BASE_LEN  base value.
REQ-008 in_last  input  1  base is the final one of the sequence; qualified by in_valid.
REQ-009 in_ready  output  1  writer accepts in_base this cycle.
REQ-010 wr_en  output  1  FM write strobe.
REQ-011 wr_buf  output  1  target buffer.
REQ-012 wr_ram  output  $clog2(FM_RAMS_COUNT)  target RAM.
REQ-013 wr_entry  output  $clog2(FM_ENTRIES_COUNT)  target entry.
REQ-014 wr_offset  output  $clog2(FM_OFFSET_COUNT)  offset in entry.
REQ-015 wr_data  output  BASE_LEN  written base.
REQ-016 done_valid  output  1  one-cycle pulse: buffer closed and handed to reader.
REQ-017 done_buf  output  1  closed buffer id.
REQ-018 done_len  output  INDICE_LEN+1  number of valid bases in closed buffer, 1..32.
REQ-019 done_last  output  1  closed buffer holds the sequence's final base.
REQ-020 rel_valid  input  1  reader releases buffer rel_buf.
REQ-021 rel_buf  input  1  released buffer id.
REQ-022 rel_err  output  1  one-cycle pulse: release of a buffer not held by reader.

Function
REQ-023 State: cur (buffer being filled), ptr (0..31), full[1:0] (buffer owned by reader); all registered.
REQ-024 in_ready SHALL equal !full[cur], combinational from registers only; never depends on in_valid.
REQ-025 Accept = in_valid && in_ready; on accept, next cycle wr_en=1, wr_buf=cur, wr_data=in_base, address from ptr: wr_ram=ptr/16, wr_entry=(ptr%16)/2, wr_offset=ptr%2; latency exactly 1 cycle.
REQ-026 wr_en SHALL be 0 in any cycle following a non-accept cycle; other wr_* hold last value.
REQ-027 Accept with ptr<31 and in_last=0: ptr increments, cur unchanged.
REQ-028 Close on accept with ptr==31 or in_last=1: next cycle done_valid=1, done_buf=cur, done_len=ptr+1, done_last=in_last, concurrent with the final wr_en; full[cur] set; cur toggles; ptr=0.
REQ-029 If the newly selected buffer is already full, in_ready is 0 until its release; no base lost or duplicated.
REQ-030 rel_valid with full[rel_buf]=1: full[rel_buf] cleared next cycle; in_ready may rise that next cycle.
REQ-031 rel_valid with full[rel_buf]=0: no state change; rel_err=1 next cycle.
REQ-032 Release of buffer X in the same cycle as close of buffer Y (X!=Y): both take effect; full[X]=0, full[Y]=1.
REQ-033 Release targeting the buffer being closed in the same cycle: treated as REQ-031 (not held), close proceeds normally.
REQ-034 After a close with done_last=1, the next accepted base starts a new sequence in the toggled buffer at ptr=0.
REQ-035 done_len width INDICE_LEN+1 = 6 bits; value 32 representable; no wrap.

Reset
REQ-036 On rst: cur=0, ptr=0, full=2'b00, wr_en=0, done_valid=0, rel_err=0, wr_buf/wr_ram/wr_entry/wr_offset/wr_data/done_buf/done_len/done_last=0; in_ready=1 the cycle after rst deasserts.
REQ-037 rst mid-fill discards the partial buffer; no done_valid is issued for it; rst has priority over accept and release.

Verification
REQ-038 Stream 32 bases 0,1,2,3,... (mod 4), no release -> wr addresses ram0 entry0 off0 ... ram1 entry7 off1 in buffer 0; done_valid, done_buf=0, done_len=32, done_last=0; in_ready stays 1 (buffer 1 free).
REQ-039 Continue 32 more bases without release -> buffer 1 filled, done_buf=1; in_ready=0 from the cycle after the close; 65th base stalls until rel_valid rel_buf=0, then accepted into buffer 0 ptr 0.
REQ-040 5 bases with in_last on 5th -> done_len=5, done_last=1, done_buf=0; next base written to buffer 1, ptr 0.
REQ-041 rel_valid rel_buf=1 while full=2'b00 -> rel_err pulse, full unchanged, in_ready unchanged.
REQ-042 Both buffers full, rel of buffer 0 coinciding with in_valid -> base not accepted that cycle, accepted the following cycle; exactly one wr_en per base.
REQ-043 rst asserted after 10 bases of buffer 0 -> no done_valid; next base written to buffer 0, ram0 entry0 off0.

Source files
------------

// File: rtl/fm_writer.sv
// FM base writer: packs an incoming base stream into two ping-pong buffers,
// hands closed buffers to a reader and takes them back on release.
module fm_writer #(
    parameter int BASE_LEN         = 2,
    parameter int FM_BUFFER_COUNT  = 2,
    parameter int FM_RAMS_COUNT    = 2,
    parameter int FM_ENTRIES_COUNT = 8,
    parameter int FM_OFFSET_COUNT  = 2,
    localparam int FM_BUFFER_SIZE  = FM_RAMS_COUNT * FM_ENTRIES_COUNT * FM_OFFSET_COUNT,
    localparam int INDICE_LEN      = $clog2(FM_BUFFER_SIZE),
    localparam int RAM_W           = $clog2(FM_RAMS_COUNT),
    localparam int ENT_W           = $clog2(FM_ENTRIES_COUNT),
    localparam int OFF_W           = $clog2(FM_OFFSET_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [BASE_LEN-1:0]   in_base,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic                  wr_buf,
    output logic [RAM_W-1:0]      wr_ram,
    output logic [ENT_W-1:0]      wr_entry,
    output logic [OFF_W-1:0]      wr_offset,
    output logic [BASE_LEN-1:0]   wr_data,
    output logic                  done_valid,
    output logic                  done_buf,
    output logic [INDICE_LEN:0]   done_len,
    output logic                  done_last,
    input  logic                  rel_valid,
    input  logic                  rel_buf,
    output logic                  rel_err
);

    localparam logic [INDICE_LEN-1:0] PTR_MAX = INDICE_LEN'(FM_BUFFER_SIZE - 1);

    logic                       r_cur;
    logic [INDICE_LEN-1:0]      r_ptr;
    logic [FM_BUFFER_COUNT-1:0] r_full;

    logic                       w_accept;
    logic                       w_close;
    logic                       w_rel_ok;
    logic [FM_BUFFER_COUNT-1:0] w_full_nxt;

    assign in_ready = !r_full[r_cur];
    assign w_accept = in_valid && in_ready;
    assign w_close  = w_accept && (r_ptr == PTR_MAX || in_last);
    // The buffer being closed is never held, so a release aimed at it is an error.
    assign w_rel_ok = rel_valid && r_full[rel_buf];

    always_comb begin
        w_full_nxt = r_full;
        if (w_rel_ok) w_full_nxt[rel_buf] = 1'b0;
        if (w_close)  w_full_nxt[r_cur]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur      <= 1'b0;
            r_ptr      <= '0;
            r_full     <= '0;
            wr_en      <= 1'b0;
            wr_buf     <= 1'b0;
            wr_ram     <= '0;
            wr_entry   <= '0;
            wr_offset  <= '0;
            wr_data    <= '0;
            done_valid <= 1'b0;
            done_buf   <= 1'b0;
            done_len   <= '0;
            done_last  <= 1'b0;
            rel_err    <= 1'b0;
        end else begin
            r_full     <= w_full_nxt;
            wr_en      <= w_accept;
            done_valid <= w_close;
            rel_err    <= rel_valid && !r_full[rel_buf];
            if (w_accept) begin
                wr_buf    <= r_cur;
                wr_ram    <= r_ptr[OFF_W+ENT_W +: RAM_W];
                wr_entry  <= r_ptr[OFF_W +: ENT_W];
                wr_offset <= r_ptr[OFF_W-1:0];
                wr_data   <= in_base;
                if (w_close) begin
                    done_buf  <= r_cur;
                    done_len  <= {1'b0, r_ptr} + (INDICE_LEN+1)'(1);
                    done_last <= in_last;
                    r_cur     <= ~r_cur;
                    r_ptr     <= '0;
                end else begin
                    r_ptr <= r_ptr + INDICE_LEN'(1);
                end
            end
        end
    end

endmodule
